// File: rtl/ecall_io_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ecall_io_responder_pkg
// Description : Shared definitions for the environment-call I/O responder.
//               Holds the a7 service codes understood by the responder, the
//               responder FSM state encoding and small extension helpers used
//               when building read results.
// Contents    : SVC_* service codes (3 bits, a7[2:0])
//               io_state_t       responder FSM states
//               zext16 / zext8 / sext8  read-result helpers
// Revision    : 1.0  initial release
// ============================================================================
package ecall_io_responder_pkg;

   // Service codes carried in a7[2:0]
   localparam logic [2:0] SVC_RD_SW16    = 3'd0;  // read 16 switches, zero-ext
   localparam logic [2:0] SVC_RD_SW8     = 3'd1;  // read low 8 switches, zero-ext
   localparam logic [2:0] SVC_RD_SW8S    = 3'd2;  // read low 8 switches, sign-ext
   localparam logic [2:0] SVC_RD_CONFIRM = 3'd3;  // wait for confirm, read switches
   localparam logic [2:0] SVC_WR_LED     = 3'd4;  // a0 -> LED register
   localparam logic [2:0] SVC_WR_SEG     = 3'd5;  // a0 -> seven-segment value

   // Responder FSM state encoding (explicit 2-bit width)
   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_REL   = 2'd1,
      ST_WAIT_PRESS = 2'd2,
      ST_DONE       = 2'd3
   } io_state_t;

   function automatic logic [31:0] zext16(input logic [15:0] v);
      return {16'h0000, v};
   endfunction

   function automatic logic [31:0] zext8(input logic [7:0] v);
      return {24'h000000, v};
   endfunction

   function automatic logic [31:0] sext8(input logic [7:0] v);
      return {{24{v[7]}}, v};
   endfunction

endpackage : ecall_io_responder_pkg
`default_nettype wire

// File: rtl/ecall_io_responder_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Synchronises a raw, bouncy push-button and debounces it.
//               The debounced level only changes after the synchronised input
//               has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
//               A one-cycle rise pulse accompanies every 0->1 level change.
// Ports       : clock   in   system clock, rising edge
//               reset   in   asynchronous, active-high reset
//               raw_in  in   raw button (asynchronous to clock)
//               level   out  debounced level (registered)
//               rise    out  one-cycle pulse, high in the first cycle level=1
// Revision    : 1.0  initial release
// ============================================================================
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 200000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_in,
   output logic level,
   output logic rise
);

   // One spare bit so the counter can represent DEBOUNCE_CYCLES-1 for any
   // value, including exact powers of two; it is cleared before it could wrap.
   localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

   logic               r_meta;
   logic               r_sync;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_level;
   logic               r_rise;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
      end else begin
         r_meta <= raw_in;
         r_sync <= r_meta;
         r_rise <= 1'b0;
         if (r_sync == r_level) begin
            // Any agreement restarts the stability window.
            r_cnt <= '0;
         end else if (r_cnt == c_cnt_last) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
            r_rise  <= ~r_level;   // only a 0->1 flip produces a pulse
         end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
         end
      end
   end

   assign level = r_level;
   assign rise  = r_rise;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/ecall_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : ecall_io_responder
// Description : Peripheral-side responder for ecall I/O services. Samples the
//               board switches, waits for the debounced confirm button when
//               asked, and drives the LED and seven-segment value registers.
//               Stalls the CPU until each request completes and returns the
//               read result for register write-back.
// Ports       : clock        in   system clock, rising edge
//               reset        in   asynchronous, active-high reset
//               io_read      in   read request (services 0..3)
//               io_write     in   write request (services 4..5)
//               svc          in   service code a7[2:0], valid with a request
//               wdata        in   a0 value for write services
//               switch_in    in   raw board switches (asynchronous)
//               confirm_btn  in   raw confirm button (asynchronous, bouncy)
//               rdata        out  read result, valid in the io_done cycle
//               io_stall     out  hold PC / suppress write-back (combinational)
//               io_done      out  one-cycle completion pulse
//               led_out      out  LED register
//               seg_value    out  seven-segment value register
// Revision    : 1.0  initial release
// ============================================================================
module ecall_io_responder #(
   parameter int DEBOUNCE_CYCLES = 200000,
   parameter int SW_WIDTH        = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                io_read,
   input  logic                io_write,
   input  logic [2:0]          svc,
   input  logic [31:0]         wdata,
   input  logic [SW_WIDTH-1:0] switch_in,
   input  logic                confirm_btn,
   output logic [31:0]         rdata,
   output logic                io_stall,
   output logic                io_done,
   output logic [SW_WIDTH-1:0] led_out,
   output logic [31:0]         seg_value
);

   import ecall_io_responder_pkg::*;

   // ------------------------------------------------------------------
   // Switch synchroniser (2 flops) and 32-bit zero-extended view
   // ------------------------------------------------------------------
   logic [SW_WIDTH-1:0] r_sw_meta;
   logic [SW_WIDTH-1:0] r_sw_sync;
   logic [31:0]         w_sw_ext;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sw_meta <= '0;
         r_sw_sync <= '0;
      end else begin
         r_sw_meta <= switch_in;
         r_sw_sync <= r_sw_meta;
      end
   end

   generate
      if (SW_WIDTH < 32) begin : g_sw_pad
         assign w_sw_ext = {{(32 - SW_WIDTH){1'b0}}, r_sw_sync};
      end else begin : g_sw_full
         assign w_sw_ext = r_sw_sync[31:0];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Confirm button: synchronised and debounced in the sub-module
   // ------------------------------------------------------------------
   logic w_btn_level;
   logic w_btn_rise;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clock  (clock),
      .reset  (reset),
      .raw_in (confirm_btn),
      .level  (w_btn_level),
      .rise   (w_btn_rise)
   );

   // ------------------------------------------------------------------
   // Immediate read result for services completed straight from IDLE.
   // Unknown read services return zero.
   // ------------------------------------------------------------------
   logic [31:0] w_read_data;

   always_comb begin
      w_read_data = 32'h0;
      case (svc)
         SVC_RD_SW16: w_read_data = zext16(w_sw_ext[15:0]);
         SVC_RD_SW8:  w_read_data = zext8(w_sw_ext[7:0]);
         SVC_RD_SW8S: w_read_data = sext8(w_sw_ext[7:0]);
         default:     w_read_data = 32'h0;
      endcase
   end

   // ------------------------------------------------------------------
   // Responder FSM with registered outputs
   // ------------------------------------------------------------------
   io_state_t           r_state;
   logic [31:0]         r_rdata;
   logic [SW_WIDTH-1:0] r_led;
   logic [31:0]         r_seg;
   logic                r_done;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_rdata <= 32'h0;
         r_led   <= '0;
         r_seg   <= 32'h0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // Read has priority when both request lines are high.
               if (io_read && (svc == SVC_RD_CONFIRM)) begin
                  r_state <= ST_WAIT_REL;
               end else if (io_read) begin
                  r_rdata <= w_read_data;
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else if (io_write) begin
                  case (svc)
                     SVC_WR_LED: r_led <= wdata[SW_WIDTH-1:0];
                     SVC_WR_SEG: r_seg <= wdata;
                     default:    ;   // unknown write: complete with no effect
                  endcase
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end

            // A button still held from an earlier confirm must be released
            // first, otherwise one long press would satisfy two reads.
            ST_WAIT_REL: begin
               if (!w_btn_level) begin
                  r_state <= ST_WAIT_PRESS;
               end
            end

            ST_WAIT_PRESS: begin
               if (w_btn_rise) begin
                  r_rdata <= w_sw_ext;
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end

            // The request lines are still high here for the same instruction,
            // so they are deliberately ignored.
            ST_DONE: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Stall must rise in the very cycle a request appears, hence combinational.
   assign io_stall = ((r_state == ST_IDLE) && (io_read || io_write)) ||
                     (r_state == ST_WAIT_REL) ||
                     (r_state == ST_WAIT_PRESS);

   assign io_done   = r_done;
   assign rdata     = r_rdata;
   assign led_out   = r_led;
   assign seg_value = r_seg;

endmodule : ecall_io_responder
`default_nettype wire

// File: tb/tb_ecall_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ecall_io_responder
// Description : Self-checking bench for ecall_io_responder. Fixed vector
//               table, randomized requests against a reference model, and
//               hand-written confirm-button, held-button and reset sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ecall_io_responder;

   logic        clock;
   logic        reset;
   logic        io_read;
   logic        io_write;
   logic [2:0]  svc;
   logic [31:0] wdata;
   logic [15:0] switch_in;
   logic        confirm_btn;
   logic [31:0] rdata;
   logic        io_stall;
   logic        io_done;
   logic [15:0] led_out;
   logic [31:0] seg_value;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [31:0] m_rdata;
   logic [15:0] m_led;
   logic [31:0] m_seg;

   ecall_io_responder #(
      .DEBOUNCE_CYCLES (4),
      .SW_WIDTH        (16)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .io_read     (io_read),
      .io_write    (io_write),
      .svc         (svc),
      .wdata       (wdata),
      .switch_in   (switch_in),
      .confirm_btn (confirm_btn),
      .rdata       (rdata),
      .io_stall    (io_stall),
      .io_done     (io_done),
      .led_out     (led_out),
      .seg_value   (seg_value)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   // Reference read result computed with plain arithmetic on the switch value.
   function automatic logic [31:0] model_read(input int s, input int sw);
      int v;
      case (s)
         0: return 32'(sw % 65536);
         1: return 32'(sw % 256);
         2: begin
            v = sw % 256;
            if (v >= 128) v = v - 256;
            return 32'(v);
         end
         default: return 32'h0;
      endcase
   endfunction

   // Single-cycle service: settle switches, raise request, check stall,
   // check completion one cycle later, drop request after the DONE cycle.
   task automatic do_req(input string tag, input logic rd, input logic wr,
                         input logic [2:0] s, input logic [31:0] wd, input logic [15:0] sw,
                         input logic [31:0] e_rd, input logic [15:0] e_led, input logic [31:0] e_seg);
      @(posedge clock); #1;
      switch_in = sw;
      repeat (3) @(posedge clock);
      #1;
      io_read = rd; io_write = wr; svc = s; wdata = wd;
      @(negedge clock);
      chk({tag, "_stall_req"}, 32'(io_stall), 32'd1);
      chk({tag, "_done_req"},  32'(io_done),  32'd0);
      @(posedge clock); #1;
      @(negedge clock);
      chk({tag, "_done"},  32'(io_done),  32'd1);
      chk({tag, "_stall"}, 32'(io_stall), 32'd0);
      chk({tag, "_rdata"}, rdata, e_rd);
      chk({tag, "_led"},   32'(led_out), 32'(e_led));
      chk({tag, "_seg"},   seg_value, e_seg);
      @(posedge clock); #1;
      io_read = 1'b0; io_write = 1'b0;
      @(negedge clock);
      chk({tag, "_done_clear"}, 32'(io_done), 32'd0);
   endtask

   // Wait (bounded) for io_done; returns number of rising edges taken.
   task automatic wait_done(input int limit, output int lat, output logic seen);
      lat  = 0;
      seen = 1'b0;
      while (lat < limit && !seen) begin
         @(posedge clock);
         lat++;
         @(negedge clock);
         if (io_done) seen = 1'b1;
      end
   endtask

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  s;
      logic [31:0] wd;
      logic [15:0] sw;
      logic [31:0] e_rd;
      logic [15:0] e_led;
      logic [31:0] e_seg;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int   lat;
      logic seen;
      int   errs;

      vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h0,        16'hA5C3, 32'h0000A5C3, 16'h0000, 32'h00000000};
      vecs[1]  = '{1'b1, 1'b0, 3'd2, 32'h0,        16'h0080, 32'hFFFFFF80, 16'h0000, 32'h00000000};
      vecs[2]  = '{1'b1, 1'b0, 3'd1, 32'h0,        16'h0080, 32'h00000080, 16'h0000, 32'h00000000};
      vecs[3]  = '{1'b0, 1'b1, 3'd4, 32'h1234FFFF, 16'h0080, 32'h00000080, 16'hFFFF, 32'h00000000};
      vecs[4]  = '{1'b0, 1'b1, 3'd5, 32'hDEADBEEF, 16'h0080, 32'h00000080, 16'hFFFF, 32'hDEADBEEF};
      vecs[5]  = '{1'b0, 1'b1, 3'd6, 32'h55555555, 16'h0080, 32'h00000080, 16'hFFFF, 32'hDEADBEEF};
      vecs[6]  = '{1'b1, 1'b0, 3'd0, 32'h0,        16'h7F7F, 32'h00007F7F, 16'hFFFF, 32'hDEADBEEF};
      vecs[7]  = '{1'b1, 1'b1, 3'd5, 32'h0BADF00D, 16'h7F7F, 32'h00000000, 16'hFFFF, 32'hDEADBEEF};
      vecs[8]  = '{1'b1, 1'b0, 3'd2, 32'h0,        16'h127F, 32'h0000007F, 16'hFFFF, 32'hDEADBEEF};
      vecs[9]  = '{1'b0, 1'b1, 3'd4, 32'hCAFE1234, 16'h127F, 32'h0000007F, 16'h1234, 32'hDEADBEEF};
      vecs[10] = '{1'b1, 1'b0, 3'd7, 32'h0,        16'hFFFF, 32'h00000000, 16'h1234, 32'hDEADBEEF};
      vecs[11] = '{1'b0, 1'b1, 3'd3, 32'h00000001, 16'hFFFF, 32'h00000000, 16'h1234, 32'hDEADBEEF};

      reset = 1'b0; io_read = 1'b0; io_write = 1'b0; svc = 3'd0;
      wdata = 32'h0; switch_in = 16'h0; confirm_btn = 1'b0;
      #2 reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_led",   32'(led_out), 32'h0);
      chk("rst_seg",   seg_value, 32'h0);
      chk("rst_done",  32'(io_done), 32'h0);
      chk("rst_stall", 32'(io_stall), 32'h0);
      @(posedge clock); #1 reset = 1'b0;

      // ---------------- table vectors ----------------
      for (int i = 0; i < 12; i++) begin
         do_req($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].s, vecs[i].wd,
                vecs[i].sw, vecs[i].e_rd, vecs[i].e_led, vecs[i].e_seg);
      end
      m_rdata = vecs[11].e_rd;
      m_led   = vecs[11].e_led;
      m_seg   = vecs[11].e_seg;

      // ---------------- randomized requests vs model ----------------
      for (int i = 0; i < 40; i++) begin
         int          pick;
         int          mode;
         int          s;
         logic [15:0] sw;
         logic [31:0] wd;
         pick = int'($urandom_range(0, 6));
         s    = (pick < 3) ? pick : pick + 1;   // never the confirm service
         mode = int'($urandom_range(0, 2));     // 0 read, 1 write, 2 both
         sw   = 16'($urandom);
         wd   = $urandom;
         if (mode != 1) begin
            m_rdata = model_read(s, int'(sw));
         end else if (s == 4) begin
            m_led = wd[15:0];
         end else if (s == 5) begin
            m_seg = wd;
         end
         do_req($sformatf("rnd%0d", i), mode != 1, mode != 0, 3'(s), wd, sw,
                m_rdata, m_led, m_seg);
      end

      // ---------------- confirm read with bouncy press ----------------
      @(posedge clock); #1;
      switch_in = 16'h3C5A; confirm_btn = 1'b0;
      repeat (3) @(posedge clock);
      #1 io_read = 1'b1; svc = 3'd3;
      errs = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (!io_stall || io_done) errs++;
      end
      chk("cfm_stall50", 32'(errs), 32'd0);
      @(posedge clock); #1 confirm_btn = 1'b1;
      @(posedge clock); #1 confirm_btn = 1'b0;
      @(posedge clock); #1 confirm_btn = 1'b1;
      @(posedge clock); #1 confirm_btn = 1'b0;
      @(posedge clock); #1 confirm_btn = 1'b1;
      // 2 sync edges + 4 stable cycles + 1 FSM edge
      wait_done(20, lat, seen);
      chk("cfm_done_seen", 32'(seen), 32'd1);
      chk("cfm_latency",   32'(lat),  32'd7);
      chk("cfm_rdata",     rdata, 32'h00003C5A);
      chk("cfm_stall_done", 32'(io_stall), 32'd0);
      @(posedge clock); #1 io_read = 1'b0;

      // ---------------- held button ----------------
      @(posedge clock); #1 switch_in = 16'h0F0F;
      repeat (3) @(posedge clock);
      #1 io_read = 1'b1; svc = 3'd3;
      errs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (!io_stall || io_done) errs++;
      end
      chk("held_no_done", 32'(errs), 32'd0);
      @(posedge clock); #1 confirm_btn = 1'b0;
      errs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (!io_stall || io_done) errs++;
      end
      chk("held_release_no_done", 32'(errs), 32'd0);
      @(posedge clock); #1 switch_in = 16'hBEEF;
      repeat (3) @(posedge clock);
      #1 confirm_btn = 1'b1;
      wait_done(20, lat, seen);
      chk("held_done_seen", 32'(seen), 32'd1);
      chk("held_latency",   32'(lat),  32'd7);
      chk("held_rdata",     rdata, 32'h0000BEEF);
      @(posedge clock); #1 io_read = 1'b0; confirm_btn = 1'b0;
      repeat (8) @(posedge clock);

      // ---------------- reset in WAIT_PRESS ----------------
      do_req("pre_led", 1'b0, 1'b1, 3'd4, 32'h0000ABCD, 16'h0, 32'h0000BEEF, 16'hABCD, m_seg);
      do_req("pre_seg", 1'b0, 1'b1, 3'd5, 32'h12345678, 16'h0, 32'h0000BEEF, 16'hABCD, 32'h12345678);
      @(posedge clock); #1 io_read = 1'b1; svc = 3'd3;
      repeat (5) @(posedge clock);
      @(negedge clock);
      chk("rstmid_stall_before", 32'(io_stall), 32'd1);
      #2 reset = 1'b1; io_read = 1'b0;
      #1;
      chk("rstmid_stall", 32'(io_stall), 32'd0);
      chk("rstmid_led",   32'(led_out), 32'h0);
      chk("rstmid_seg",   seg_value, 32'h0);
      chk("rstmid_rdata", rdata, 32'h0);
      chk("rstmid_done",  32'(io_done), 32'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      do_req("post_rst", 1'b1, 1'b0, 3'd0, 32'h0, 16'h1357, 32'h00001357, 16'h0000, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #400000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_ecall_io_responder
`default_nettype wire

// File: doc/ecall_io_responder.md
Name: ecall_io_responder

Overview:
- Peripheral-side responder for the environment-call I/O protocol.
- The control unit raises io_read for services a7=0..3 and io_write for services a7=4..5 on `ecall`. This block services each request: it samples the board switches, waits for a debounced confirm button, and drives the LEDs and the seven-segment value register.
- It stalls the CPU until the request completes and returns read data for the register write-back mux.
- Sits between the decoder/register file and the board I/O pins.

Parameters:
- DEBOUNCE_CYCLES, default 200000: number of consecutive stable cycles before the confirm button's debounced level changes (2 ms at 100 MHz). Bench overrides this to 4.
- SW_WIDTH, default 16: number of switch inputs.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_read  in  1  ecall read request from the control unit.
- io_write  in  1  ecall write request from the control unit.
- svc  in  3  service code, a7[2:0]. Valid only while io_read or io_write is high.
- wdata  in  32  a0 value for write services.
- switch_in  in  SW_WIDTH  raw board switches (asynchronous).
- confirm_btn  in  1  raw confirm button (asynchronous, bouncy).
- rdata  out  32  read result; valid in the io_done cycle.
- io_stall  out  1  CPU must hold PC and suppress write-back.
- io_done  out  1  one-cycle completion pulse.
- led_out  out  SW_WIDTH  LED register.
- seg_value  out  32  value register for the seven-segment driver.

Behaviour:
- Reset (asynchronous, active-high): all outputs, registers and FSM state go to 0 or IDLE immediately, including a request in progress. The debouncer counter and level are cleared.
- Input synchronisation: switch_in and confirm_btn each pass through a 2-flop synchroniser before any use.
- FSM states: IDLE, WAIT_REL, WAIT_PRESS, DONE.
- IDLE:
  - if io_read and svc==3: go to WAIT_REL.
  - else if io_read or io_write: go to DONE and perform the action (below) at this edge.
  - io_read has priority if both are high.
- WAIT_REL: wait until the debounced button is 0, then go to WAIT_PRESS. This prevents a held button from completing two reads.
- WAIT_PRESS: on a debounced 0->1 edge, capture the zero-extended synced switches into rdata and go to DONE.
- DONE:
  - io_done=1, io_stall=0; rdata holds the result.
  - Always returns to IDLE next cycle.
  - Requests present in DONE are ignored; this is the same instruction still being held.
- io_stall = (state==IDLE & (io_read|io_write)) | state==WAIT_REL | state==WAIT_PRESS. It is combinational.
- Read actions, on the IDLE edge:
  - svc 0: rdata = zero-extended sw[15:0].
  - svc 1: rdata = zero-extended sw[7:0].
  - svc 2: rdata = sign-extended sw[7:0].
  - any other svc with io_read: rdata = 0.
- Write actions:
  - svc 4: led_out <= wdata[SW_WIDTH-1:0].
  - svc 5: seg_value <= wdata.
  - any other svc: no state change, but the request still completes through DONE.
  - rdata is unchanged on writes.
- Latency:
  - services 0,1,2,4,5: request cycle plus 1, i.e. io_done in the cycle after the request first appears in IDLE.
  - service 3: unbounded (waits for the button), then 1 cycle.
- Debouncer: the counter increments while the synced input differs from the current debounced level and resets to 0 when they match. When the count reaches DEBOUNCE_CYCLES-1, the level flips and the counter clears. Counter width is clog2(DEBOUNCE_CYCLES)+1; it never wraps.
- Hold rules:
  - led_out and seg_value hold their values between writes.
  - rdata holds until the next read completes.

Decomposition:
- Shared package holds:
  - service code constants SVC_RD_SW16=0, SVC_RD_SW8=1, SVC_RD_SW8S=2, SVC_RD_CONFIRM=3, SVC_WR_LED=4, SVC_WR_SEG=5.
  - FSM state encoding.
- One sub-module: btn_debounce (clock, reset, raw in, debounced level out, rise pulse out), which includes its own 2-flop synchroniser.
- Switch synchroniser and FSM stay in the top module.

Test Plan:
- Read, svc=0: switch_in=16'hA5C3, io_read=1, svc=0 for one cycle -> io_stall=1 that cycle; next cycle io_done=1, rdata=32'h0000A5C3, io_stall=0.
- Sign/zero extension: switch_in=16'h0080, svc=2 -> rdata=32'hFFFFFF80; same switches, svc=1 -> rdata=32'h00000080.
- Confirm read: DEBOUNCE_CYCLES=4, svc=3 held with button low -> io_stall stays high for 50 cycles. Then a bouncy press (1,0,1,0, then stable 1): io_done fires only after 4 stable cycles plus sync delay, with rdata equal to the switches.
- Held button: button already high when svc=3 is issued -> no completion until the button is released (stable low) and pressed again.
- Writes: io_write, svc=4, wdata=32'h1234FFFF -> led_out=16'hFFFF. Then svc=5, wdata=32'hDEADBEEF -> seg_value=32'hDEADBEEF, led_out unchanged. Then svc=6 -> io_done pulses, nothing changes.
- Reset mid-operation: reset asserted asynchronously while in WAIT_PRESS -> io_stall=0, led_out=0, seg_value=0 immediately. After release, a new svc=0 read completes normally.
